// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a runtime bit period, feeding a FIFO write port.
// Reports framing errors and bytes dropped because the FIFO was full.
module uart_rx (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [20:0] prescaler_in,
  input  logic        full,
  output logic [7:0]  data,
  output logic        wr,
  output logic        rx_active,
  output logic        frame_err,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q, rx_d_q;
  logic [20:0] cnt_q, cnt_d, p_q, p_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic wr_q, wr_d, fe_q, fe_d, ov_q, ov_d;
  logic fall, half_hit, bit_hit, stop_hit;
  assign fall     = rx_d_q & ~rx_s_q;
  assign half_hit = cnt_q == (p_q >> 1) - 21'd1;
  assign bit_hit  = cnt_q == p_q - 21'd1;
  assign stop_hit = state_q == STOP && bit_hit;
  // Synchronizer flops come out of reset high so an idle line never looks like an edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      {rx_m_q, rx_s_q, rx_d_q} <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      {rx_m_q, rx_s_q, rx_d_q} <= {RX, rx_m_q, rx_s_q};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (half_hit) state_d = rx_s_q ? IDLE : DATA;
      DATA:    if (bit_hit && idx_q == 3'd7) state_d = STOP;
      STOP:    if (bit_hit) state_d = rx_s_q ? IDLE : BRK;
      BRK:     if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = (state_q == IDLE || (state_q == START && half_hit) ||
              ((state_q == DATA || state_q == STOP) && bit_hit)) ? '0 : cnt_q + 21'd1;
    p_d    = (state_q == IDLE && fall) ? prescaler_in : p_q;
    idx_d  = state_q == IDLE ? '0 : (state_q == DATA && bit_hit) ? idx_q + 3'd1 : idx_q;
    sh_d   = (state_q == DATA && bit_hit) ? {rx_s_q, sh_q[7:1]} : sh_q;
    wr_d   = stop_hit & rx_s_q & ~full;
    ov_d   = stop_hit & rx_s_q & full;
    fe_d   = stop_hit & ~rx_s_q;
    data_d = wr_d ? sh_q : data_q;
  end
  assign data      = data_q;
  assign wr        = wr_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign rx_active = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames at bit-level and compares received bytes and status pulses.
module tb_uart_rx;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [20:0] prescaler_in = 21'd104;
  logic        full = 1'b0;
  logic [7:0]  data;
  logic        wr, rx_active, frame_err, overrun;
  int passed = 0, total = 0;
  int cyc = 0, wr_n = 0, fe_n = 0, ov_n = 0, multi = 0, act_n = 0;
  int wr_cyc[$];
  logic [7:0] got[$];
  uart_rx dut (
    .CLK(CLK), .rst_n(rst_n), .RX(RX), .prescaler_in(prescaler_in), .full(full),
    .data(data), .wr(wr), .rx_active(rx_active), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (wr) begin
      got.push_back(data);
      wr_cyc.push_back(cyc);
      wr_n++;
    end
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (int'(wr) + int'(frame_err) + int'(overrun) > 1) multi++;
    if (rx_active) act_n++;
  end
  task automatic clear_obs();
    wr_n = 0; fe_n = 0; ov_n = 0; act_n = 0;
    got.delete();
    wr_cyc.delete();
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop, output int t0);
    t0 = cyc;
    RX = 1'b0;
    idle(p);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      idle(p);
    end
    RX = stop;
    idle(p);
  endtask
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask
  task automatic test_reset();
    idle(3);
    check("reset_outputs", {data, wr, rx_active, frame_err, overrun}, 0);
    rst_n = 1'b1;
    idle(10);
    check("post_reset_idle", {wr, rx_active, frame_err, overrun}, 0);
  endtask
  task automatic test_single();
    int t0;
    clear_obs();
    prescaler_in = 21'd104;
    send_frame(8'h55, 104, 1'b1, t0);
    idle(20);
    check("single_wr_count", wr_n, 1);
    check("single_data", got.size() > 0 ? int'(got[0]) : -1, 8'h55);
    check("single_latency", wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1, 52 + 9 * 104 + 3);
    check("single_no_err", fe_n + ov_n, 0);
  endtask
  task automatic test_back_to_back();
    int t0, t1;
    clear_obs();
    send_frame(8'hA3, 104, 1'b1, t0);
    send_frame(8'h0F, 104, 1'b1, t1);
    idle(20);
    check("b2b_wr_count", wr_n, 2);
    check("b2b_first", got.size() > 1 ? int'(got[0]) : -1, 8'hA3);
    check("b2b_second", got.size() > 1 ? int'(got[1]) : -1, 8'h0F);
    check("b2b_spacing", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, 1040);
  endtask
  task automatic test_glitch();
    clear_obs();
    RX = 1'b0;
    idle(30);
    RX = 1'b1;
    idle(150);
    check("glitch_no_pulse", wr_n + fe_n + ov_n, 0);
    check("glitch_active_short", int'(act_n > 0 && act_n < 60), 1);
    check("glitch_active_low", rx_active, 0);
  endtask
  task automatic test_frame_err();
    int t0;
    logic [7:0] prev;
    prev = data;
    clear_obs();
    send_frame(8'h7E, 104, 1'b0, t0);
    idle(3 * 104);
    check("ferr_held_active", rx_active, 1);
    RX = 1'b1;
    idle(20);
    check("ferr_count", fe_n, 1);
    check("ferr_no_wr", wr_n + ov_n, 0);
    check("ferr_data_kept", data, prev);
    check("ferr_back_idle", rx_active, 0);
    idle(200);
  endtask
  task automatic test_overrun();
    int t0;
    logic [7:0] prev;
    prev = data;
    clear_obs();
    full = 1'b1;
    send_frame(8'hC4, 104, 1'b1, t0);
    idle(20);
    full = 1'b0;
    check("ovr_count", ov_n, 1);
    check("ovr_no_wr", wr_n + fe_n, 0);
    check("ovr_data_kept", data, prev);
    clear_obs();
    send_frame(8'hC4, 104, 1'b1, t0);
    idle(20);
    check("ovr_retry_wr", wr_n, 1);
    check("ovr_retry_data", data, 8'hC4);
  endtask
  task automatic test_mid_reset();
    int t0;
    logic [7:0] b;
    clear_obs();
    b = 8'hA5;
    RX = 1'b0;
    idle(104);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      idle(104);
    end
    RX = b[4];
    idle(52);
    rst_n = 1'b0;
    RX = 1'b1;
    #1;
    check("midrst_immediate", {data, wr, rx_active, frame_err, overrun}, 0);
    idle(5);
    rst_n = 1'b1;
    idle(1200);
    check("midrst_no_output", wr_n + fe_n + ov_n, 0);
    send_frame(8'h31, 104, 1'b1, t0);
    idle(20);
    check("midrst_wr_count", wr_n, 1);
    check("midrst_data", data, 8'h31);
  endtask
  task automatic test_random();
    int t0, p;
    logic [7:0] exp_q[$];
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      p = n == 0 ? 8 : int'($urandom_range(8, 60));
      prescaler_in = 21'(p);
      exp_q.push_back(b);
      t0 = cyc;
      RX = 1'b0;
      idle(4);
      prescaler_in = 21'($urandom_range(8, 300));
      idle(p - 4);
      for (int i = 0; i < 8; i++) begin
        RX = b[i];
        idle(p);
      end
      RX = 1'b1;
      idle(p + int'($urandom_range(0, 5)));
    end
    idle(20);
    check("rand_wr_count", wr_n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_byte%0d", i), i < got.size() ? int'(got[i]) : -1, exp_q[i]);
    check("rand_no_err", fe_n + ov_n, 0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_random();
    check("pulses_exclusive", multi, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
